exc_flush_ctrl: RTL

//  Exception/interrupt sequencer at the WB end of the 5-stage MIPS pipeline. Arbitrates
//  WB exception causes, ERET and pending interrupts into one committed event per cycle.

---
 rtl/exc_flush_ctrl_if.sv | 55 +++++
 rtl/exc_flush_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/exc_flush_ctrl_if.sv
// exc_flush_ctrl_if: WB/CP0/IF signal bundle for the exception sequencer; timer ports under EXC_TIMER_INT_EN.
interface exc_flush_ctrl_if;
  logic        ws_valid;
  logic [6:0]  ws_exc;
  logic        ws_eret;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic [31:0] ws_badvaddr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        fs_redir_ready;
  logic        flush;
  logic        ws_commit_en;
  logic        cp0_exc_we;
  logic        cp0_eret_we;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_epc_wdata;
  logic        cp0_bd;
  logic [31:0] cp0_badvaddr;
  logic [5:0]  cp0_ip_hw;
  logic        fs_redir_valid;
  logic [31:0] fs_redir_pc;
`ifdef EXC_TIMER_INT_EN
  logic        cp0_cmp_we;
  logic [31:0] cp0_cmp_wdata;
  logic [31:0] cp0_count;
  logic        ti;
  modport master(
    output ws_valid, ws_exc, ws_eret, ws_pc, ws_bd, ws_badvaddr, hw_int, cp0_status, cp0_epc,
           fs_redir_ready, cp0_cmp_we, cp0_cmp_wdata,
    input  flush, ws_commit_en, cp0_exc_we, cp0_eret_we, cp0_exc_code, cp0_epc_wdata, cp0_bd,
           cp0_badvaddr, cp0_ip_hw, fs_redir_valid, fs_redir_pc, cp0_count, ti
  );
  modport slave(
    input  ws_valid, ws_exc, ws_eret, ws_pc, ws_bd, ws_badvaddr, hw_int, cp0_status, cp0_epc,
           fs_redir_ready, cp0_cmp_we, cp0_cmp_wdata,
    output flush, ws_commit_en, cp0_exc_we, cp0_eret_we, cp0_exc_code, cp0_epc_wdata, cp0_bd,
           cp0_badvaddr, cp0_ip_hw, fs_redir_valid, fs_redir_pc, cp0_count, ti
  );
`else
  modport master(
    output ws_valid, ws_exc, ws_eret, ws_pc, ws_bd, ws_badvaddr, hw_int, cp0_status, cp0_epc,
           fs_redir_ready,
    input  flush, ws_commit_en, cp0_exc_we, cp0_eret_we, cp0_exc_code, cp0_epc_wdata, cp0_bd,
           cp0_badvaddr, cp0_ip_hw, fs_redir_valid, fs_redir_pc
  );
  modport slave(
    input  ws_valid, ws_exc, ws_eret, ws_pc, ws_bd, ws_badvaddr, hw_int, cp0_status, cp0_epc,
           fs_redir_ready,
    output flush, ws_commit_en, cp0_exc_we, cp0_eret_we, cp0_exc_code, cp0_epc_wdata, cp0_bd,
           cp0_badvaddr, cp0_ip_hw, fs_redir_valid, fs_redir_pc
  );
`endif
endinterface

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: WB exception/interrupt/ERET sequencer driving flush, CP0 strobes and IF redirect.
// EXC_TIMER_INT_EN adds an internal count/compare timer interrupt on cp0_ip_hw[5].
module exc_flush_ctrl #(
  parameter logic [31:0] EXC_ENTRY   = 32'hbfc00380,
  parameter int          SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset,
  exc_flush_ctrl_if.slave bus
);
  typedef enum logic {IDLE, REDIR} state_t;
  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic        timer_bit;
  logic        int_pend, exc_any, evt_exc, evt_eret, idle;
  logic [4:0]  code;
  logic        unused_ok;
  assign unused_ok = ^{bus.cp0_status[31:16], bus.cp0_status[9:2]};
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
`ifdef EXC_TIMER_INT_EN
  logic        half_q, ti_q;
  logic [31:0] count_q, compare_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q    <= 1'b0;
      ti_q      <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      half_q <= ~half_q;
      if (half_q) count_q <= count_q + 32'd1;
      if (bus.cp0_cmp_we) compare_q <= bus.cp0_cmp_wdata;
      ti_q <= bus.cp0_cmp_we ? 1'b0 : (ti_q | (count_q == compare_q));
    end
  end
  assign bus.cp0_count = count_q;
  assign bus.ti        = ti_q;
  assign timer_bit     = ti_q;
`else
  assign timer_bit = 1'b0;
`endif
  assign bus.cp0_ip_hw = {sync_q[SYNC_STAGES-1][5] | timer_bit, sync_q[SYNC_STAGES-1][4:0]};
  // exc bits: {ov,ri,bp,sys,ades,adel_d,adel_f}
  assign int_pend = bus.cp0_status[0] & ~bus.cp0_status[1] & |(bus.cp0_status[15:10] & bus.cp0_ip_hw);
  assign exc_any  = |bus.ws_exc;
  assign evt_exc  = bus.ws_valid & (int_pend | exc_any);
  assign evt_eret = bus.ws_valid & bus.ws_eret & ~int_pend & ~exc_any;
  assign idle     = (state_q == IDLE) & ~reset;
  assign code = int_pend       ? 5'h00 :
                bus.ws_exc[0]  ? 5'h04 :
                bus.ws_exc[5]  ? 5'h0a :
                bus.ws_exc[6]  ? 5'h0c :
                bus.ws_exc[3]  ? 5'h08 :
                bus.ws_exc[4]  ? 5'h09 :
                bus.ws_exc[1]  ? 5'h04 : 5'h05;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end
  always_comb begin
    state_d            = state_q;
    target_d           = target_q;
    bus.flush          = 1'b0;
    bus.ws_commit_en   = 1'b0;
    bus.cp0_exc_we     = 1'b0;
    bus.cp0_eret_we    = 1'b0;
    bus.cp0_exc_code   = '0;
    bus.cp0_epc_wdata  = '0;
    bus.cp0_bd         = 1'b0;
    bus.cp0_badvaddr   = '0;
    bus.fs_redir_valid = 1'b0;
    bus.fs_redir_pc    = '0;
    if (idle) begin
      bus.flush        = evt_exc | evt_eret;
      bus.ws_commit_en = bus.ws_valid & ~evt_exc & ~evt_eret;
      bus.cp0_exc_we   = evt_exc;
      bus.cp0_eret_we  = evt_eret;
      if (evt_exc) begin
        bus.cp0_exc_code  = code;
        bus.cp0_epc_wdata = bus.ws_bd ? bus.ws_pc - 32'd4 : bus.ws_pc;
        bus.cp0_bd        = bus.ws_bd;
        bus.cp0_badvaddr  = (!int_pend && bus.ws_exc[0]) ? bus.ws_pc : bus.ws_badvaddr;
      end
      if (evt_exc || evt_eret) begin
        state_d  = REDIR;
        target_d = evt_eret ? bus.cp0_epc : EXC_ENTRY;
      end
    end else if (state_q == REDIR && !reset) begin
      bus.fs_redir_valid = 1'b1;
      bus.fs_redir_pc    = target_q;
      state_d            = bus.fs_redir_ready ? IDLE : REDIR;
    end
  end
endmodule
